// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared state encoding and phase-time clamp for the step pulse train
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } step_state_t;

  // A programmed phase time of zero still yields a one-cycle phase.
  function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - loadable down-counter that stops at zero and flags it
module step_timer #(
  parameter int TMR_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/step_pulse_train.sv
// rtl/step_pulse_train.sv - burst generator for STEP/DIR with setup time, abort and status
module step_pulse_train
  import step_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int TMR_W     = 16,
  parameter int SETUP_CYC = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             SP,
  input  logic             ABORT,
  input  logic             DIR_IN,
  input  logic [CNT_W-1:0] NUM_STEPS,
  input  logic [TMR_W-1:0] HIGH_CYC,
  input  logic [TMR_W-1:0] LOW_CYC,
  output logic             STEP,
  output logic             DIR,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] STEP_CNT
);

  step_state_t state, state_nxt;

  logic             sp_dly;
  logic             start;
  logic [CNT_W-1:0] num_lat;
  logic [TMR_W-1:0] h_lat, l_lat;
  logic             abort_pend;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             latch;
  logic             cnt_inc;
  logic             done_nxt;

  // sp_dly resets high so an SP already asserted at reset release is not an edge.
  assign start = SP & ~sp_dly & ~ABORT;
  assign BUSY  = (state != ST_IDLE);

  step_timer #(.TMR_W(TMR_W)) u_timer (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (BUSY),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    latch     = 1'b0;
    cnt_inc   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch = 1'b1;
          if (NUM_STEPS == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_SETUP;
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(SETUP_CYC - 1);
          end
        end
      end
      ST_SETUP: begin
        if (ABORT) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (tmr_zero) begin
          state_nxt = ST_HIGH;
          tmr_load  = 1'b1;
          tmr_val   = h_lat - TMR_W'(1);
        end
      end
      ST_HIGH: begin
        if (tmr_zero) begin
          state_nxt = ST_LOW;
          tmr_load  = 1'b1;
          tmr_val   = l_lat - TMR_W'(1);
          cnt_inc   = 1'b1;
        end
      end
      ST_LOW: begin
        // The low phase always runs to completion before a burst may end.
        if (tmr_zero) begin
          if ((STEP_CNT == num_lat) || abort_pend || ABORT) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_HIGH;
            tmr_load  = 1'b1;
            tmr_val   = h_lat - TMR_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sp_dly     <= 1'b1;
      STEP       <= 1'b0;
      DIR        <= 1'b0;
      DONE       <= 1'b0;
      STEP_CNT   <= '0;
      num_lat    <= '0;
      h_lat      <= TMR_W'(1);
      l_lat      <= TMR_W'(1);
      abort_pend <= 1'b0;
    end else begin
      sp_dly <= SP;
      STEP   <= (state_nxt == ST_HIGH);
      DONE   <= done_nxt;
      if (latch) begin
        num_lat    <= NUM_STEPS;
        h_lat      <= TMR_W'(clamp_to_one(32'(HIGH_CYC)));
        l_lat      <= TMR_W'(clamp_to_one(32'(LOW_CYC)));
        DIR        <= DIR_IN;
        STEP_CNT   <= '0;
        abort_pend <= 1'b0;
      end else begin
        if (cnt_inc) begin
          STEP_CNT <= STEP_CNT + CNT_W'(1);
        end
        if (ABORT && ((state == ST_HIGH) || (state == ST_LOW))) begin
          abort_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_train.sv
// tb/tb_step_pulse_train.sv - self-checking bench for step_pulse_train
module tb_step_pulse_train;

  localparam int CNT_W     = 16;
  localparam int TMR_W     = 16;
  localparam int SETUP_CYC = 2;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             SP;
  logic             ABORT;
  logic             DIR_IN;
  logic [CNT_W-1:0] NUM_STEPS;
  logic [TMR_W-1:0] HIGH_CYC;
  logic [TMR_W-1:0] LOW_CYC;
  logic             STEP;
  logic             DIR;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] STEP_CNT;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic step;
    logic busy;
    logic done;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   done_idx;

  step_pulse_train #(
    .CNT_W     (CNT_W),
    .TMR_W     (TMR_W),
    .SETUP_CYC (SETUP_CYC)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .SP        (SP),
    .ABORT     (ABORT),
    .DIR_IN    (DIR_IN),
    .NUM_STEPS (NUM_STEPS),
    .HIGH_CYC  (HIGH_CYC),
    .LOW_CYC   (LOW_CYC),
    .STEP      (STEP),
    .DIR       (DIR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .STEP_CNT  (STEP_CNT)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Expected per-cycle view of a burst, cycle 1 being the first after the start edge.
  task automatic build_model(input int n, input int h, input int l, input int a);
    int  hc, lc, cnt, win_start;
    bit  stop;
    hc = (h == 0) ? 1 : h;
    lc = (l == 0) ? 1 : l;
    cnt = 0;
    exp_q.delete();
    if (n == 0) begin
      exp_q.push_back('{1'b0, 1'b0, 1'b1, 0});
    end else begin
      stop = 1'b0;
      for (int s = 1; s <= SETUP_CYC; s++) begin
        exp_q.push_back('{1'b0, 1'b1, 1'b0, 0});
        if (a == s) begin
          stop = 1'b1;
          break;
        end
      end
      if (!stop) begin
        for (int k = 1; k <= n; k++) begin
          win_start = exp_q.size() + 1;
          repeat (hc) exp_q.push_back('{1'b1, 1'b1, 1'b0, k - 1});
          repeat (lc) exp_q.push_back('{1'b0, 1'b1, 1'b0, k});
          cnt = k;
          if ((k == n) || (a >= win_start && a <= exp_q.size())) break;
        end
      end
      exp_q.push_back('{1'b0, 1'b0, 1'b1, cnt});
    end
    done_idx = exp_q.size();
    exp_q.push_back('{1'b0, 1'b0, 1'b0, cnt});
  endtask

  // sp_mode: 0 SP high until done, 1 SP held high throughout, 2 SP and data inputs random while busy
  task automatic run_burst(input int n, input int h, input int l, input logic d,
                           input int a, input int sp_mode);
    build_model(n, h, l, a);
    @(negedge CLK);
    SP = 1'b0;
    ABORT = 1'b0;
    @(negedge CLK);
    NUM_STEPS = CNT_W'(n);
    HIGH_CYC  = TMR_W'(h);
    LOW_CYC   = TMR_W'(l);
    DIR_IN    = d;
    SP        = 1'b1;
    for (int i = 1; i <= exp_q.size(); i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("step n%0d c%0d", n, i), 32'(STEP), 32'(exp_q[i-1].step));
      check($sformatf("busy n%0d c%0d", n, i), 32'(BUSY), 32'(exp_q[i-1].busy));
      check($sformatf("done n%0d c%0d", n, i), 32'(DONE), 32'(exp_q[i-1].done));
      check($sformatf("cnt n%0d c%0d", n, i), 32'(STEP_CNT), 32'(exp_q[i-1].cnt));
      check($sformatf("dir n%0d c%0d", n, i), 32'(DIR), 32'(d));
      ABORT = (a != 0) && (i == a);
      if (i < done_idx) begin
        SP = (sp_mode == 2) ? 1'($urandom) : 1'b1;
        if (sp_mode == 2) begin
          NUM_STEPS = CNT_W'($urandom);
          HIGH_CYC  = TMR_W'($urandom);
          LOW_CYC   = TMR_W'($urandom);
          DIR_IN    = 1'($urandom);
        end
      end else begin
        SP = (sp_mode == 1);
      end
    end
    @(negedge CLK);
    ABORT = 1'b0;
  endtask

  initial begin
    int n, h, l, a, m;
    logic d;
    RSTn = 1'b0;
    SP = 1'b1;
    ABORT = 1'b0;
    DIR_IN = 1'b1;
    NUM_STEPS = 16'd3;
    HIGH_CYC = 16'd2;
    LOW_CYC = 16'd2;
    repeat (3) @(posedge CLK);
    #1;
    check("rst step", 32'(STEP), 32'd0);
    check("rst dir", 32'(DIR), 32'd0);
    check("rst busy", 32'(BUSY), 32'd0);
    check("rst done", 32'(DONE), 32'd0);
    check("rst cnt", 32'(STEP_CNT), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("sp_at_release busy %0d", i), 32'(BUSY), 32'd0);
      check($sformatf("sp_at_release done %0d", i), 32'(DONE), 32'd0);
    end

    run_burst(3, 2, 3, 1'b1, 0, 0);
    run_burst(0, 5, 5, 1'b0, 0, 0);
    run_burst(2, 0, 0, 1'b1, 0, 0);
    run_burst(10, 4, 4, 1'b0, 12, 0);
    run_burst(4, 2, 2, 1'b1, 1, 0);
    run_burst(3, 1, 2, 1'b0, 8, 0);

    run_burst(1, 1, 1, 1'b1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("sp_held busy %0d", i), 32'(BUSY), 32'd0);
      check($sformatf("sp_held done %0d", i), 32'(DONE), 32'd0);
    end
    run_burst(2, 1, 2, 1'b0, 0, 2);

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 5);
      h = $urandom_range(0, 4);
      l = $urandom_range(0, 4);
      d = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
      m = ($urandom_range(0, 1) == 1) ? 2 : 0;
      run_burst(n, h, l, d, a, m);
    end

    @(negedge CLK);
    SP = 1'b0;
    @(negedge CLK);
    NUM_STEPS = 16'd3;
    HIGH_CYC = 16'd4;
    LOW_CYC = 16'd4;
    DIR_IN = 1'b1;
    SP = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("midhigh step before reset", 32'(STEP), 32'd1);
    RSTn = 1'b0;
    #1;
    check("midhigh reset step", 32'(STEP), 32'd0);
    check("midhigh reset cnt", 32'(STEP_CNT), 32'd0);
    check("midhigh reset busy", 32'(BUSY), 32'd0);
    check("midhigh reset dir", 32'(DIR), 32'd0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check($sformatf("post reset done %0d", i), 32'(DONE), 32'd0);
      check($sformatf("post reset busy %0d", i), 32'(BUSY), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
